// File: rtl/tdm_demux_four.sv
// Four-channel TDM receiver: deserialises WIDTH-bit slots from a framed serial
// stream into four parallel channel registers, with hunt/lock frame alignment.
module tdm_demux_four #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 din,
  input  logic                 sync,
  output logic [4*WIDTH-1:0]   q,
  output logic [3:0]           valid,
  output logic                 locked,
  output logic                 sync_err
);

  localparam int BW = $clog2(WIDTH);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t               state, state_nx;
  logic [BW-1:0]        bit_cnt, bit_cnt_nx;
  logic [1:0]           slot_cnt, slot_cnt_nx;
  logic [WIDTH-2:0]     shift, shift_nx;
  logic [4*WIDTH-1:0]   q_nx;
  logic [3:0]           valid_nx;
  logic                 err_nx;
  logic [WIDTH-1:0]     word;
  logic                 frame_start;

  assign word        = {shift, din};
  assign frame_start = (bit_cnt == '0) && (slot_cnt == 2'd0);
  assign locked      = (state == LOCKED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HUNT;
      bit_cnt  <= '0;
      slot_cnt <= 2'd0;
      shift    <= '0;
      q        <= '0;
      valid    <= 4'd0;
      sync_err <= 1'b0;
    end else begin
      state    <= state_nx;
      bit_cnt  <= bit_cnt_nx;
      slot_cnt <= slot_cnt_nx;
      shift    <= shift_nx;
      q        <= q_nx;
      valid    <= valid_nx;
      sync_err <= err_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    bit_cnt_nx  = bit_cnt;
    slot_cnt_nx = slot_cnt;
    shift_nx    = shift;
    q_nx        = q;
    valid_nx    = 4'd0;
    err_nx      = 1'b0;
    if (en) begin
      case (state)
        HUNT: begin
          if (sync) begin
            state_nx    = LOCKED;
            shift_nx    = word[WIDTH-2:0];
            bit_cnt_nx  = BW'(1);
            slot_cnt_nx = 2'd0;
          end
        end
        LOCKED: begin
          if (frame_start && !sync) begin
            state_nx    = HUNT;
            err_nx      = 1'b1;
            bit_cnt_nx  = '0;
            slot_cnt_nx = 2'd0;
          end else if (sync && !frame_start) begin
            // Early sync wins over slot completion: the partial slot is dropped.
            err_nx      = 1'b1;
            shift_nx    = word[WIDTH-2:0];
            bit_cnt_nx  = BW'(1);
            slot_cnt_nx = 2'd0;
          end else if (bit_cnt == BW'(WIDTH-1)) begin
            q_nx[slot_cnt*WIDTH +: WIDTH] = word;
            valid_nx[slot_cnt]            = 1'b1;
            bit_cnt_nx                    = '0;
            slot_cnt_nx                   = slot_cnt + 2'd1;
          end else begin
            shift_nx   = word[WIDTH-2:0];
            bit_cnt_nx = bit_cnt + 1'b1;
          end
        end
        default: state_nx = HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_demux_four.sv
// Randomised scoreboard bench for tdm_demux_four with a frame-position model.
module tb_tdm_demux_four;

  localparam int W = 8;
  localparam int FB = 4 * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          din = 1'b0;
  logic          sync = 1'b0;
  logic [FB-1:0] q;
  logic [3:0]    valid;
  logic          locked;
  logic          sync_err;

  tdm_demux_four #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .sync(sync),
    .q(q), .valid(valid), .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_err;
    int            slot;
    logic [FB-1:0] qv;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  // Reference model: frame position and accumulated slot value
  bit            m_lk;
  int            m_pos;
  int            m_cur;
  logic [FB-1:0] m_q;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lk = 0; m_pos = 0; m_cur = 0; m_q = '0;
  endtask

  task automatic model_sample(input bit s, input bit d);
    exp_t e;
    if (!m_lk) begin
      if (s) begin
        m_lk = 1; m_cur = int'(d); m_pos = 1;
      end
    end else if (m_pos == 0 && !s) begin
      m_lk = 0;
      e.is_err = 1; e.slot = 0; e.qv = m_q;
      exp_q.push_back(e);
    end else if (s && m_pos != 0) begin
      m_cur = int'(d); m_pos = 1;
      e.is_err = 1; e.slot = 0; e.qv = m_q;
      exp_q.push_back(e);
    end else begin
      m_cur = m_cur * 2 + int'(d);
      m_pos = m_pos + 1;
      if (m_pos % W == 0) begin
        e.slot = (m_pos - 1) / W;
        m_q[e.slot*W +: W] = W'(m_cur);
        e.is_err = 0; e.qv = m_q;
        exp_q.push_back(e);
        m_cur = 0;
        m_pos = m_pos % FB;
      end
    end
  endtask

  // One clock cycle of stimulus; idle cycles carry random din/sync to prove they are ignored
  task automatic cycle(input bit e, input bit s, input bit d);
    @(negedge clk);
    en = e; sync = s; din = d;
    @(posedge clk);
    if (e && rst_n) model_sample(s, d);
    #1;
    check("locked", 64'(locked), 64'(m_lk));
  endtask

  task automatic send_bit(input bit s, input bit d, input int gap);
    cycle(1'b1, s, d);
    for (int g = 0; g < gap; g++) cycle(1'b0, 1'($urandom), 1'($urandom));
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit first_sync, input int nbits, input int gap);
    for (int i = 0; i < nbits; i++) send_bit(first_sync && i == 0, w[W-1-i], gap);
  endtask

  task automatic send_frame(input logic [FB-1:0] f, input int gap);
    for (int k = 0; k < 4; k++) send_word(f[k*W +: W], k == 0, W, gap);
  endtask

  task automatic async_reset();
    check("pending_before_reset", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_q", 64'(q), 64'd0);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_locked", 64'(locked), 64'd0);
    check("rst_sync_err", 64'(sync_err), 64'd0);
    model_reset();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: pops one expectation whenever the DUT presents valid or sync_err
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && (valid != 4'd0 || sync_err)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 64'({valid, sync_err}), 64'd0);
      end else begin
        e = exp_q.pop_front();
        if (e.is_err) check("sync_err_pulse", 64'({valid, sync_err}), 64'h1);
        else check("valid_pulse", 64'({valid, sync_err}), 64'({4'(1 << e.slot), 1'b0}));
        check("q_value", 64'(q), 64'(e.qv));
      end
    end
  end

  localparam logic [FB-1:0] FRAME1 = 32'h01FF3CA5;

  initial begin
    logic [FB-1:0] f;
    model_reset();
    #1;
    check("init_q", 64'(q), 64'd0);
    check("init_valid", 64'(valid), 64'd0);
    check("init_locked", 64'(locked), 64'd0);
    check("init_sync_err", 64'(sync_err), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Nominal frame, en held high
    send_frame(FRAME1, 0);
    #2;
    check("frame1_q", 64'(q), 64'(FRAME1));
    // Same frame with en every other cycle
    send_frame(FRAME1, 1);
    #2;
    check("frame1_gap_q", 64'(q), 64'(FRAME1));
    // Random back-to-back frames
    for (int n = 0; n < 4; n++) begin
      f = FB'({$urandom, $urandom});
      send_frame(f, 0);
    end

    // Reset, then unsynchronised bits must not lock or produce output
    async_reset();
    for (int i = 0; i < 40; i++) send_bit(1'b0, 1'($urandom), 0);
    check("hunt_q", 64'(q), 64'd0);
    send_frame(FRAME1, 0);
    #2;
    check("relock_q", 64'(q), 64'(FRAME1));

    // Early sync at slot 1 bit 4
    send_frame(FRAME1, 0);
    send_word(8'h5A, 1'b1, W, 0);
    send_word(8'hC3, 1'b0, 4, 0);
    send_frame(32'h76543210, 0);

    // Missing sync at frame boundary
    send_frame(FRAME1, 0);
    send_word(8'h81, 1'b0, W, 0);
    #2;
    check("missing_sync_q", 64'(q), 64'(FRAME1));

    // Reset mid slot 2, then no valid until a fresh sync
    send_frame(FRAME1, 0);
    send_word(8'h12, 1'b1, W, 0);
    send_word(8'h34, 1'b0, W, 0);
    send_word(8'h56, 1'b0, 3, 0);
    async_reset();
    for (int i = 0; i < 20; i++) send_bit(1'b0, 1'($urandom), 0);
    send_frame(32'hDEADBEEF, 0);

    // Random stress: random en, occasional sync, mostly aligned frames
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 3) != 0),
            ($urandom_range(0, 40) == 0) || (m_lk && m_pos == 0 && $urandom_range(0, 9) != 0) ||
            (!m_lk && $urandom_range(0, 4) == 0),
            1'($urandom));
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
